// File: rtl/md_pkg.sv
// +--------------------------------------------------------------------------+
// | md_pkg : shared encodings and default latencies for the MIPS mult/div    |
// |          unit (md_unit, md_calc).                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MD_DEF_MULT_CYCLES = 5;
    localparam int MD_DEF_DIV_CYCLES  = 10;

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_calc.sv
// +--------------------------------------------------------------------------+
// | md_calc : combinational {hi,lo} result generator for mult/multu/div/divu.|
// |           Divider present only when MD_UNIT_DIV_EN is defined.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             accept,
    output logic             write
);

    logic                 w_sgn;
    logic                 w_is_div;
    logic [2*WIDTH-1:0]   w_ea;
    logic [2*WIDTH-1:0]   w_eb;
    logic [2*WIDTH-1:0]   w_prod;

    // Signed ops have op[0]=0; extending to 2*WIDTH makes one multiplier serve both.
    assign w_sgn    = ~op[0];
    assign w_is_div = op[1];
    assign w_ea     = w_sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign w_eb     = w_sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign w_prod   = w_ea * w_eb;

`ifdef MD_UNIT_DIV_EN
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_dvsr;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Magnitude division; most-negative / -1 wraps back to most-negative with rem 0.
    assign w_neg_a    = w_sgn & src_a[WIDTH-1];
    assign w_neg_b    = w_sgn & src_b[WIDTH-1];
    assign w_mag_a    = w_neg_a ? (~src_a + 1'b1) : src_a;
    assign w_mag_b    = w_neg_b ? (~src_b + 1'b1) : src_b;
    assign w_div_zero = (src_b == '0);
    assign w_dvsr     = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    assign w_q        = w_mag_a / w_dvsr;
    assign w_r        = w_mag_a % w_dvsr;
    assign w_quo      = (w_neg_a ^ w_neg_b) ? (~w_q + 1'b1) : w_q;
    assign w_rem      = w_neg_a ? (~w_r + 1'b1) : w_r;
`endif

    always_comb begin
        hi_next = w_prod[2*WIDTH-1:WIDTH];
        lo_next = w_prod[WIDTH-1:0];
        accept  = 1'b1;
        write   = 1'b1;
        if (w_is_div) begin
`ifdef MD_UNIT_DIV_EN
            hi_next = w_rem;
            lo_next = w_quo;
            write   = ~w_div_zero;
`else
            accept  = 1'b0;
            write   = 1'b0;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// +--------------------------------------------------------------------------+
// | md_unit : multi-cycle multiply/divide unit with HI/LO registers.         |
// |           DIV/DIVU enabled by defining MD_UNIT_DIV_EN.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh_hi;
    logic [WIDTH-1:0] r_sh_lo;
    logic             r_sh_we;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_accept;
    logic             w_write;

    md_calc #(
        .WIDTH   (WIDTH)
    ) u_calc (
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .hi_next (w_hi_next),
        .lo_next (w_lo_next),
        .accept  (w_accept),
        .write   (w_write)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_sh_hi <= '0;
            r_sh_lo <= '0;
            r_sh_we <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    // start takes priority over mthi/mtlo, even when it is a no-op.
                    if (start) begin
                        if (w_accept) begin
                            r_sh_hi <= w_hi_next;
                            r_sh_lo <= w_lo_next;
                            r_sh_we <= w_write;
                            r_cnt   <= op[1] ? DIV_CNT : MULT_CNT;
                            r_busy  <= 1'b1;
                            r_state <= MD_BUSY;
                        end
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == CNT_ONE) begin
                        if (r_sh_we) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the EX stage and executes mult, multu, div, divu, mthi and mtlo. It holds results in HI/LO after a configurable latency, during which it asserts busy so the hazard logic can stall mfhi, mflo and further MD instructions.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu. Legal values are ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu. Legal values are ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  launch the operation given by op. Sampled only when busy=0.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  mthi: HI <= wdata.
- lo_we  in  1  mtlo: LO <= wdata.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM with two states.
  - IDLE: start=1 latches the computed result into shadow registers, loads the counter with MULT_CYCLES or DIV_CYCLES, and moves to BUSY.
  - BUSY: the counter decrements each cycle. At count 1, shadow values are copied to HI/LO, done is set, and the FSM returns to IDLE.
- MULT: {HI,LO} = signed src_a × signed src_b, full 2·WIDTH product.
- MULTU: {HI,LO} is the same product, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- DIVU: same as DIV, unsigned.
- Divide by zero: the operation runs the full latency, then HI/LO stay unchanged and done still pulses.
- DIV with most-negative ÷ −1: LO = most-negative value, HI = 0.
- Operands are sampled only at the start edge. Later changes on src_a/src_b have no effect.
- start while busy=1: ignored. The core must stall and never issue it.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we in IDLE: write on that edge. hi_we and lo_we may both be set together.
- start together with hi_we/lo_we in IDLE: start wins and the mt write is dropped.
- Reset mid-operation: the operation is abandoned.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, FSM=IDLE, counter=0.
- start seen at edge E0 gives:
  - busy=1 from E0 through E(L), exactly L cycles, where L is the latency for the op.
  - HI/LO take the new values at E(L).
  - busy=0 and done=1 for the cycle after E(L).
- Back-to-back launch: start may be asserted in the cycle after busy falls. This gives one issue per L+1 cycles.
- hi/lo are register outputs with no combinational path from any input.
- busy is a register output. The core builds its stall as start|busy.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Configuration
- MD_UNIT_DIV_EN defined: DIV/DIVU are supported as described above.
- MD_UNIT_DIV_EN undefined: divider logic is removed. start with op=DIV/DIVU is treated as a no-op: no busy, HI/LO unchanged, no done. MULT/MULTU and mthi/mtlo are unaffected.

## Structure
- Shared package md_pkg: op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, FSM state type {MD_IDLE, MD_BUSY}, default latencies.
- Sub-module md_calc: purely combinational, computes {hi_next, lo_next} from op, src_a and src_b. It contains the divide-by-zero and overflow handling and is the only place MD_UNIT_DIV_EN gates logic.
- md_unit itself holds the FSM, counter, shadow registers, HI/LO and the write-port priority.

## Test plan
- MULT, src_a=0xFFFFFFFE (−2), src_b=3, default latency:
  - busy high for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
- DIVU 7/0 with prior hi=5, lo=9:
  - 10 busy cycles, done pulses.
  - hi=5, lo=9 unchanged.
- mthi 0x1234 while busy: ignored, hi equals the mult result. mtlo 0xABCD in IDLE: lo=0xABCD on the next edge.
- Reset asserted mid-DIV, two cycles after start:
  - busy, done, hi and lo drop to 0 immediately, with no done afterwards.
  - With MD_UNIT_DIV_EN undefined, a DIV start leaves busy=0 and hi/lo unchanged.
